// File: rtl/cdc_pkg.sv
// Shared types and limits for the toggle-based MCP receive crossing.
package cdc_pkg;

    // Receive buffer occupancy; VALID_O is a direct decode of RX_FULL.
    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

    // Fewest synchronizer flops tolerated on the incoming request toggle.
    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage : cdc_pkg

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer.
// Ports:
//   clk_i   destination clock
//   rst_ni  async active-low reset, clears every stage to 0
//   d_i     asynchronous input bit
//   q_o     synchronized bit (last stage)
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; stage 0 is the only flop allowed to go metastable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/cdc_mcp_ack_rx.sv
// Receive end of a toggle-based multi-cycle-path crossing (destination clock).
// Each edge on toggle_i captures data_i once, offers it via valid/ready, and
// returns an ack toggle when the word leaves (popped or dropped).
// Ports:
//   clk_i, rst_ni      destination clock, async active-low reset
//   toggle_i           asynchronous request toggle from the sender
//   data_i             sender data, held stable while a request is outstanding
//   data_o, valid_o    captured word and its valid flag
//   ready_i            consumer accepts data_o when valid_o && ready_i
//   ack_toggle_o       acknowledge toggle back to the sender
//   overrun_o          sticky: request arrived while a word was held
//   clr_overrun_i      synchronous clear of overrun_o (a set wins)
//   rx_count_o         accepted-word counter, wraps silently
module cdc_mcp_ack_rx
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 toggle_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ack_toggle_o,
    output logic                 overrun_o,
    input  logic                 clr_overrun_i,
    output logic [CNT_WIDTH-1:0] rx_count_o
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_sync_check
        $error("cdc_mcp_ack_rx: SYNC_STAGES below MIN_SYNC_STAGES");
    end

    rx_state_e            state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 ack_q, ack_d;
    logic                 ovr_q, ovr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hist_q;
    logic                 sync_last;
    logic                 ld_c;
    logic                 ovr_set;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (toggle_i),
        .q_o    (sync_last)
    );

    // One-cycle load pulse per request edge; data_i is MCP-stable here.
    assign ld_c = sync_last ^ hist_q;

    // Next-state: capture, pop, drop and ack decisions.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        ovr_set = 1'b0;
        unique case (state_q)
            RX_EMPTY: begin
                if (ld_c) begin
                    data_d  = data_i;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = RX_FULL;
                end
            end
            RX_FULL: begin
                if (ld_c && ready_i) begin
                    // Ack covers the popped word; the new one replaces it.
                    ack_d   = ~ack_q;
                    data_d  = data_i;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    ovr_set = 1'b1;
                end else if (ld_c) begin
                    // New word dropped but still acked so the sender can proceed.
                    ack_d   = ~ack_q;
                    ovr_set = 1'b1;
                end else if (ready_i) begin
                    ack_d   = ~ack_q;
                    state_d = RX_EMPTY;
                end
            end
            default: state_d = RX_EMPTY;
        endcase
        ovr_d = ovr_set | (ovr_q & ~clr_overrun_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_EMPTY;
            data_q  <= '0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            hist_q  <= sync_last;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = (state_q == RX_FULL);
    assign ack_toggle_o = ack_q;
    assign overrun_o    = ovr_q;
    assign rx_count_o   = cnt_q;

endmodule : cdc_mcp_ack_rx
